// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, field widths, exception flag bundle
// and the overflow-result helper used by the rounding back ends.
package fpu_pkg;

    typedef enum logic [1:0] {
        RNE = 2'b00,
        RTZ = 2'b01,
        RUP = 2'b10,
        RDN = 2'b11
    } rmode_e;

    localparam int EXP_MAX   = 2047;
    localparam int FRAC_W    = 52;
    localparam int MANT_IN_W = 56;

    typedef struct packed {
        logic of;
        logic uf;
        logic nx;
    } fpu_flags_t;

    // Overflow saturates to infinity only when the mode rounds away from zero
    // in the result's direction; otherwise it clamps to the largest finite.
    function automatic logic [63:0] ovf_result(input logic sign, input rmode_e rm);
        logic to_inf;
        case (rm)
            RNE:     to_inf = 1'b1;
            RTZ:     to_inf = 1'b0;
            RUP:     to_inf = !sign;
            default: to_inf = sign;
        endcase
        return to_inf ? {sign, 11'h7FF, {FRAC_W{1'b0}}}
                      : {sign, 11'h7FE, {FRAC_W{1'b1}}};
    endfunction

endpackage

// File: rtl/fpu_mul_round_if.sv
// Handshake bundle between the multiplier datapath, the rounding back end
// and the result arbiter.
interface fpu_mul_round_if;
    import fpu_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sign;
    logic [MANT_IN_W-1:0] in_mant;
    logic [11:0]          in_exp;
    logic                 in_shift_inexact;
    logic [1:0]           in_rmode;
    logic                 out_valid;
    logic                 out_ready;
    logic [63:0]          out_result;
    logic [2:0]           out_flags;

    modport master (
        output in_valid, in_sign, in_mant, in_exp, in_shift_inexact, in_rmode, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_mant, in_exp, in_shift_inexact, in_rmode, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );

endinterface

// File: rtl/fpu_rnd_incr.sv
// Rounding decision: round-up increment and inexact indication from the
// sign, LSB/guard/sticky bits and the active rounding mode.
module fpu_rnd_incr
    import fpu_pkg::*;
(
    input  logic   sign,
    input  logic   lsb,
    input  logic   guard,
    input  logic   sticky,
    input  logic   shift_inexact,
    input  rmode_e rmode,
    output logic   inc,
    output logic   inexact
);

    always_comb begin
        inc = 1'b0;
        case (rmode)
            RNE:     inc = guard & (sticky | lsb);
            RTZ:     inc = 1'b0;
            RUP:     inc = !sign & (guard | sticky);
            default: inc = sign & (guard | sticky);
        endcase
        inexact = guard | sticky | shift_inexact;
    end

endmodule

// File: rtl/fpu_mul_round.sv
// Double-precision multiplier rounding/packing back end, 2-stage elastic pipeline.
// Define FPU_RND_FLAGS_EN to build the exception flag logic and registers.
module fpu_mul_round
    import fpu_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    fpu_mul_round_if.slave  bus
);

    if (LATENCY != 2) begin : g_latency_chk
        $error("fpu_mul_round: LATENCY is fixed at 2");
    end

    logic              s1_valid_q, s1_valid_d;
    logic              s1_sign_q, s1_sign_d;
    rmode_e            s1_rmode_q, s1_rmode_d;
    logic [11:0]       s1_exp_q, s1_exp_d;
    logic [FRAC_W-1:0] s1_frac_q, s1_frac_d;
    logic              s1_inc_q, s1_inc_d;
    logic              s2_valid_q, s2_valid_d;
    logic [63:0]       out_result_q, out_result_d;

    logic        in_ready, accept, s1_adv, s2_adv;
    logic        inc, ovf;
    logic [62:0] mag;
    logic [63:0] res;

    assign s2_adv   = !s2_valid_q | bus.out_ready;
    assign s1_adv   = s1_valid_q & s2_adv;
    assign in_ready = !s1_valid_q | s1_adv;
    assign accept   = bus.in_valid & in_ready;

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_result = out_result_q;

`ifdef FPU_RND_FLAGS_EN
    logic nx;

    fpu_rnd_incr u_rnd (
        .sign          (bus.in_sign),
        .lsb           (bus.in_mant[2]),
        .guard         (bus.in_mant[1]),
        .sticky        (bus.in_mant[0]),
        .shift_inexact (bus.in_shift_inexact),
        .rmode         (rmode_e'(bus.in_rmode)),
        .inc           (inc),
        .inexact       (nx)
    );
`else
    logic nx_unused;

    fpu_rnd_incr u_rnd (
        .sign          (bus.in_sign),
        .lsb           (bus.in_mant[2]),
        .guard         (bus.in_mant[1]),
        .sticky        (bus.in_mant[0]),
        .shift_inexact (1'b0),
        .rmode         (rmode_e'(bus.in_rmode)),
        .inc           (inc),
        .inexact       (nx_unused)
    );
`endif

    always_comb begin
        s1_valid_d = in_ready ? bus.in_valid : s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_rmode_d = s1_rmode_q;
        s1_exp_d   = s1_exp_q;
        s1_frac_d  = s1_frac_q;
        s1_inc_d   = s1_inc_q;
        if (accept) begin
            s1_sign_d  = bus.in_sign;
            s1_rmode_d = rmode_e'(bus.in_rmode);
            s1_exp_d   = bus.in_exp;
            s1_frac_d  = bus.in_mant[FRAC_W+1:2];
            s1_inc_d   = inc;
        end
    end

    // Fraction carry ripples straight into the exponent field, which also
    // turns a rounded-up denormal into the smallest normal.
    always_comb begin
        mag = {s1_exp_q[10:0], s1_frac_q} + {62'd0, s1_inc_q};
        ovf = (s1_exp_q >= 12'(EXP_MAX)) || (mag[62:52] == 11'(EXP_MAX));
        res = ovf ? ovf_result(s1_sign_q, s1_rmode_q) : {s1_sign_q, mag};
        s2_valid_d   = s2_adv ? s1_valid_q : s2_valid_q;
        out_result_d = (s2_adv & s1_valid_q) ? res : out_result_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_rmode_q   <= RNE;
            s1_exp_q     <= '0;
            s1_frac_q    <= '0;
            s1_inc_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            out_result_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_rmode_q   <= s1_rmode_d;
            s1_exp_q     <= s1_exp_d;
            s1_frac_q    <= s1_frac_d;
            s1_inc_q     <= s1_inc_d;
            s2_valid_q   <= s2_valid_d;
            out_result_q <= out_result_d;
        end
    end

`ifdef FPU_RND_FLAGS_EN
    logic       s1_nx_q, s1_nx_d;
    logic       s1_zero_q, s1_zero_d;
    fpu_flags_t out_flags_q, out_flags_d;
    fpu_flags_t flags;

    always_comb begin
        s1_nx_d   = accept ? nx : s1_nx_q;
        s1_zero_d = accept ? (bus.in_exp == '0 && bus.in_mant == '0) : s1_zero_q;
        flags.of  = ovf;
        flags.nx  = s1_nx_q | ovf;
        flags.uf  = !ovf & (mag[62:52] == '0) & s1_nx_q;
        if (s1_zero_q) flags = '0;
        out_flags_d = (s2_adv & s1_valid_q) ? flags : out_flags_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_nx_q     <= 1'b0;
            s1_zero_q   <= 1'b0;
            out_flags_q <= '0;
        end else begin
            s1_nx_q     <= s1_nx_d;
            s1_zero_q   <= s1_zero_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign bus.out_flags = out_flags_q;
`else
    assign bus.out_flags = 3'b000;
`endif

endmodule

// File: tb/tb_fpu_mul_round.sv
// Directed bench for fpu_mul_round: rounding vectors, latency, backpressure, reset.
module tb_fpu_mul_round;
    import fpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    fpu_mul_round_if bus ();

    fpu_mul_round #(.LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    localparam logic [51:0] F1 = {52{1'b1}};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    function automatic logic [2:0] fl(input logic [2:0] f);
`ifdef FPU_RND_FLAGS_EN
        return f;
`else
        return 3'b000;
`endif
    endfunction

    function automatic logic [55:0] mk(input logic h, input logic [51:0] f,
                                       input logic g, input logic s);
        return {1'b0, h, f, g, s};
    endfunction

    task automatic drive(input logic sg, input logic [55:0] m, input logic [11:0] e,
                         input logic sx, input logic [1:0] rm);
        bus.in_valid         = 1'b1;
        bus.in_sign          = sg;
        bus.in_mant          = m;
        bus.in_exp           = e;
        bus.in_shift_inexact = sx;
        bus.in_rmode         = rm;
    endtask

    // One beat with out_ready high: accepted at the first edge, visible after the second.
    task automatic run_vec(input string tag, input logic sg, input logic [55:0] m,
                           input logic [11:0] e, input logic sx, input logic [1:0] rm,
                           input logic [63:0] want, input logic [2:0] wfl);
        @(negedge clk);
        drive(sg, m, e, sx, rm);
        chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, " early"}, 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk({tag, " valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, " result"}, bus.out_result, want);
        chk({tag, " flags"}, 64'(bus.out_flags), 64'(fl(wfl)));
    endtask

    logic [63:0] bp_exp [3];
    int          got, stale;

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 2'b00);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset out_result", bus.out_result, 64'd0);
        chk("reset out_flags", 64'(bus.out_flags), 64'd0);
        chk("reset in_ready", 64'(bus.in_ready), 64'd1);

        run_vec("one", 0, mk(1, 52'h0, 0, 0), 12'd1023, 0, 2'b00, 64'h3FF0_0000_0000_0000, 3'b000);
        run_vec("tie_even", 0, mk(1, 52'h0, 1, 0), 12'd1023, 0, 2'b00, 64'h3FF0_0000_0000_0000, 3'b001);
        run_vec("tie_odd", 0, mk(1, 52'h1, 1, 0), 12'd1023, 0, 2'b00, 64'h3FF0_0000_0000_0002, 3'b001);
        run_vec("carry", 0, mk(1, F1, 1, 1), 12'd1023, 0, 2'b00, 64'h4000_0000_0000_0000, 3'b001);
        run_vec("ovf_rne", 0, mk(1, F1, 1, 0), 12'd2046, 0, 2'b00, 64'h7FF0_0000_0000_0000, 3'b101);
        // RTZ never increments, so the exponent stays at 2046 and no overflow is raised.
        run_vec("rtz_2046", 0, mk(1, F1, 1, 0), 12'd2046, 0, 2'b01, 64'h7FEF_FFFF_FFFF_FFFF, 3'b001);
        run_vec("ovf_rtz", 0, mk(1, F1, 1, 0), 12'd2047, 0, 2'b01, 64'h7FEF_FFFF_FFFF_FFFF, 3'b101);
        run_vec("ovf_rup_n", 1, mk(1, 52'h0, 0, 0), 12'd2047, 0, 2'b10, 64'hFFEF_FFFF_FFFF_FFFF, 3'b101);
        run_vec("ovf_rup_p", 0, mk(1, 52'h0, 0, 0), 12'd2047, 0, 2'b10, 64'h7FF0_0000_0000_0000, 3'b101);
        run_vec("ovf_rdn_p", 0, mk(1, 52'h0, 0, 0), 12'd2047, 0, 2'b11, 64'h7FEF_FFFF_FFFF_FFFF, 3'b101);
        run_vec("ovf_rdn_n", 1, mk(1, 52'h0, 0, 0), 12'd2047, 0, 2'b11, 64'hFFF0_0000_0000_0000, 3'b101);
        run_vec("denorm_up", 0, mk(0, F1, 1, 0), 12'd0, 0, 2'b10, 64'h0010_0000_0000_0000, 3'b001);
        run_vec("rdn_neg", 1, mk(1, 52'h0, 0, 1), 12'd1023, 0, 2'b11, 64'hBFF0_0000_0000_0001, 3'b001);
        run_vec("rup_neg", 1, mk(1, 52'h0, 0, 1), 12'd1023, 0, 2'b10, 64'hBFF0_0000_0000_0000, 3'b001);
        run_vec("uf_round", 0, mk(0, 52'h1, 1, 0), 12'd0, 0, 2'b00, 64'h0000_0000_0000_0002, 3'b011);
        run_vec("uf_shift", 0, mk(0, 52'h5, 0, 0), 12'd0, 1, 2'b00, 64'h0000_0000_0000_0005, 3'b011);
        run_vec("zero_neg", 1, mk(0, 52'h0, 0, 0), 12'd0, 1, 2'b00, 64'h8000_0000_0000_0000, 3'b000);

        // Backpressure: three beats offered with the consumer stalled.
        bp_exp[0] = 64'h3FF0_0000_0000_0000;
        bp_exp[1] = 64'h3FF0_0000_0000_0002;
        bp_exp[2] = 64'h4000_0000_0000_0000;
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(0, mk(1, 52'h0, 0, 0), 12'd1023, 0, 2'b00);
        chk("bp rdy0", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        drive(0, mk(1, 52'h1, 1, 0), 12'd1023, 0, 2'b00);
        chk("bp rdy1", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        drive(0, mk(1, F1, 1, 1), 12'd1023, 0, 2'b00);
        chk("bp full", 64'(bus.in_ready), 64'd0);
        chk("bp head valid", 64'(bus.out_valid), 64'd1);
        chk("bp head", bus.out_result, bp_exp[0]);
        @(negedge clk);
        chk("bp full hold", 64'(bus.in_ready), 64'd0);
        chk("bp head hold", bus.out_result, bp_exp[0]);
        bus.out_ready = 1'b1;
        #1;
        chk("bp release rdy", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        got = 1;
        for (int i = 0; i < 10 && got < 3; i++) begin
            if (bus.out_valid) begin
                chk($sformatf("bp beat%0d", got), bus.out_result, bp_exp[got]);
                got++;
            end
            @(negedge clk);
        end
        chk("bp beat count", 64'(got), 64'd3);
        chk("bp drained", 64'(bus.out_valid), 64'd0);

        // Reset with two beats in flight.
        bus.out_ready = 1'b0;
        drive(0, mk(1, 52'h0, 0, 0), 12'd1023, 0, 2'b00);
        @(negedge clk);
        drive(0, mk(1, 52'h1, 1, 0), 12'd1023, 0, 2'b00);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("rst pre valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst out_result", bus.out_result, 64'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        chk("rst in_ready", 64'(bus.in_ready), 64'd1);
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        chk("rst no stale", 64'(stale), 64'd0);
        run_vec("post_rst", 0, mk(1, F1, 1, 1), 12'd1023, 0, 2'b00, 64'h4000_0000_0000_0000, 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
